booth_seq_multiplier: RTL and testbench
=======================================

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: in_valid  input  1  operand pair and mode present.
REQ-005 Port: in_ready  output  1  block can accept operands this cycle.
REQ-006 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-007 Port: multiplicand  input  WIDTH  operand M.
REQ-008 Port: multiplier  input  WIDTH  operand Q.
REQ-009 Port: out_valid  output  1  product valid.
REQ-010 Port: out_ready  input  1  consumer accepts product.
REQ-011 Port: product  output  2*WIDTH  result, signed or unsigned per captured mode.
REQ-012 Port: busy  output  1  high in RUN and DONE.

Function
REQ-013 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE: in_ready=1, out_valid=0. An accept is in_valid & in_ready at a rising edge.
REQ-015 On accept: capture operands and mode, clear iteration counter, go to RUN.
REQ-016 Operand extension on capture: signed_mode=1 sign-extends both operands to WIDTH+1 bits; signed_mode=0 zero-extends them.
REQ-017 Accumulator A (WIDTH+1 bits) and q_1 (1 bit) are cleared on accept.
REQ-018 RUN performs one radix-2 Booth step per cycle, for exactly WIDTH+1 steps.
REQ-019 Step decode on {Q[0], q_1}: 01 -> A = A + M; 10 -> A = A - M; 00 or 11 -> no add.
REQ-020 Each step then arithmetic-shifts {A, Q, q_1} right by 1, replicating A's MSB.
REQ-021 Add/subtract is modulo 2^(WIDTH+1).
REQ-022 After step WIDTH+1, go to DONE and register product = low 2*WIDTH bits of {A, Q}.
REQ-023 Latency: out_valid rises after exactly WIDTH+1 rising edges following the accepting edge.
REQ-024 DONE: out_valid=1; product and out_valid hold stable until out_valid & out_ready at an edge, then return to IDLE.
REQ-025 in_ready=0 in RUN and DONE; in_valid there is ignored and no operand is captured.
REQ-026 Maximum throughput: one result per WIDTH+3 cycles when out_ready is held high.
REQ-027 Boundary cases:
- Most-negative × most-negative in signed mode yields exactly +2^(2*WIDTH-2).
- All-ones × all-ones in unsigned mode yields exactly (2^WIDTH-1)^2.
- Zero operands yield 0.
REQ-028 Operand inputs and signed_mode may change freely after accept without affecting the result.

Reset
REQ-029 When rst=1 at a rising edge, state -> IDLE; this holds in any state, including mid-RUN and DONE.
REQ-030 Reset values: in_ready=1 (combinational from IDLE), out_valid=0, busy=0, product=0.
REQ-031 Reset values: A=0, Q=0, M=0, q_1=0, counter=0.
REQ-032 An in-flight operation aborted by rst produces no out_valid.
REQ-033 rst has priority over a simultaneous accept.
REQ-034 The first accept is possible on the first edge with rst=0.

Verification
REQ-035 WIDTH=4, signed: 3 × -3 (4'h3, 4'hD), out_ready=1 -> out_valid 5 edges after accept, product=8'hF7 (-9), then IDLE.
REQ-036 WIDTH=4, both boundary cases:
- signed -8 × -8 -> 8'h40 (+64).
- unsigned 15 × 15 -> 8'hE1 (225).
- signed -2 × 2 -> 8'hFC.
- unsigned 0 × 9 -> 8'h00.
REQ-037 WIDTH=8, signed: -128 × -128 -> 16'h4000; unsigned 255 × 255 -> 16'hFE01; signed 127 × -1 -> 16'hFF81.
REQ-038 Backpressure: hold out_ready=0 for 10 cycles in DONE -> product and out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-039 Reset and busy handling:
- Assert rst for 1 cycle at RUN step 2 -> no out_valid, all outputs at reset values.
- Next accept of 7 × 1 -> 7.
- in_valid with new operands during RUN -> ignored; the original product is delivered.
REQ-040 Randomised: 1000 operand pairs over both modes, WIDTH=4 and 8, random out_ready -> every product equals the reference multiply, with latency per REQ-023.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : booth_seq_multiplier
// Purpose  : Sequential radix-2 Booth multiplier, one step per cycle, with
//            valid/ready handshakes and selectable signed/unsigned operands.
// Revision : 1.0 - initial release
// ============================================================================
module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int EXT_W = WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [EXT_W-1:0]     acc_q,     acc_d;
    logic [EXT_W-1:0]     mcand_q,   mcand_d;
    logic [EXT_W-1:0]     mplier_q,  mplier_d;
    logic                 q_1_q,     q_1_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [EXT_W-1:0]     w_sum;
    logic [2*EXT_W-1:0]   w_shifted;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        q_1_d     = q_1_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case ({mplier_q[0], q_1_q})
            2'b01:   w_sum = acc_q + mcand_q;
            2'b10:   w_sum = acc_q - mcand_q;
            default: w_sum = acc_q;
        endcase
        // Arithmetic right shift of {A, Q}; the bit leaving Q becomes q_1.
        w_shifted = {w_sum[EXT_W-1], w_sum, mplier_q[EXT_W-1:1]};

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Extending to WIDTH+1 bits lets unsigned operands run through the signed Booth recoding.
                    mcand_d  = {signed_mode & multiplicand[WIDTH-1], multiplicand};
                    mplier_d = {signed_mode & multiplier[WIDTH-1], multiplier};
                    acc_d    = '0;
                    q_1_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = w_shifted[2*EXT_W-1:EXT_W];
                mplier_d = w_shifted[EXT_W-1:0];
                q_1_d    = mplier_q[0];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    product_d = w_shifted[2*WIDTH-1:0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            q_1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            q_1_q     <= q_1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign product   = product_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_booth_seq_multiplier
// Purpose  : Scoreboard bench for booth_seq_multiplier at WIDTH=4 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit done_w [2];

    typedef struct {
        bit          s;
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] e;
    } dvec_t;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference product: interpret operands as integers and multiply.
    function automatic logic [63:0] ref_mul(input int w, input bit s,
                                            input logic [31:0] m, input logic [31:0] q);
        logic [63:0] mw;
        longint a, b;
        mw = (64'd1 << w) - 64'd1;
        a  = longint'({32'd0, m} & mw);
        b  = longint'({32'd0, q} & mw);
        if (s && m[w-1]) a = a - longint'(64'd1 << w);
        if (s && q[w-1]) b = b - longint'(64'd1 << w);
        return 64'(a * b) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_w
        localparam int W   = (gi == 0) ? 4 : 8;
        localparam int LAT = W + 1;

        logic             rst = 1'b1;
        logic             in_valid = 1'b0;
        logic             in_ready;
        logic             signed_mode = 1'b0;
        logic [W-1:0]     mcand = '0;
        logic [W-1:0]     mplier = '0;
        logic             out_valid;
        logic             out_ready = 1'b1;
        logic [2*W-1:0]   product;
        logic             busy;

        logic [63:0] exp_q [$];
        int          acc_q [$];
        bit          hold_off = 1'b0;
        bit          rnd_ready = 1'b0;
        int          last_acc = 0;
        dvec_t       dv [$];

        booth_seq_multiplier #(.WIDTH(W)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid),
            .in_ready     (in_ready),
            .signed_mode  (signed_mode),
            .multiplicand (mcand),
            .multiplier   (mplier),
            .out_valid    (out_valid),
            .out_ready    (out_ready),
            .product      (product),
            .busy         (busy)
        );

        always @(posedge clk) begin
            #2;
            out_ready = hold_off ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end

        // Monitor: latency on the rising edge of out_valid, product on each handshake.
        logic           prev_valid = 1'b0;
        logic [2*W-1:0] prev_prod = '0;
        always @(negedge clk) begin
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    check_eq($sformatf("w%0d result expected", W), 64'(acc_q.size() != 0), 64'd1);
                    if (acc_q.size() != 0)
                        check_eq($sformatf("w%0d latency", W), 64'(cyc - acc_q[0]), 64'(LAT));
                end
                if (out_valid && prev_valid)
                    check_eq($sformatf("w%0d product stable", W), 64'(product), 64'(prev_prod));
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    check_eq($sformatf("w%0d product", W), 64'(product), exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
                prev_valid = out_valid;
                prev_prod  = product;
            end
        end

        task automatic wait_ready();
            int n = 0;
            while (!in_ready && n < 200) begin
                @(posedge clk); #2;
                n++;
            end
            if (!in_ready) check_eq($sformatf("w%0d in_ready timeout", W), 64'(in_ready), 64'd1);
        endtask

        task automatic wait_idle();
            int n = 0;
            while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
                @(posedge clk); #2;
                n++;
            end
            if (exp_q.size() != 0 || !in_ready)
                check_eq($sformatf("w%0d drain timeout", W), 64'(exp_q.size()), 64'd0);
        endtask

        task automatic issue(input bit s, input logic [31:0] m, input logic [31:0] q,
                             input logic [63:0] e);
            wait_ready();
            in_valid    = 1'b1;
            signed_mode = s;
            mcand       = m[W-1:0];
            mplier      = q[W-1:0];
            @(posedge clk); #2;
            exp_q.push_back(e);
            acc_q.push_back(cyc);
            last_acc    = cyc;
            in_valid    = 1'b0;
            signed_mode = 1'($urandom);
            mcand       = W'($urandom);
            mplier      = W'($urandom);
        endtask

        initial begin : driver
            int a0;
            int n;
            if (W == 4) begin
                dv.push_back('{1'b1, 32'h3,  32'hD,  64'hF7});
                dv.push_back('{1'b1, 32'h8,  32'h8,  64'h40});
                dv.push_back('{1'b0, 32'hF,  32'hF,  64'hE1});
                dv.push_back('{1'b1, 32'hE,  32'h2,  64'hFC});
                dv.push_back('{1'b0, 32'h0,  32'h9,  64'h00});
            end else begin
                dv.push_back('{1'b1, 32'h80, 32'h80, 64'h4000});
                dv.push_back('{1'b0, 32'hFF, 32'hFF, 64'hFE01});
                dv.push_back('{1'b1, 32'h7F, 32'hFF, 64'hFF81});
                dv.push_back('{1'b0, 32'h00, 32'h00, 64'h0000});
            end

            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("w%0d reset in_ready", W),  64'(in_ready),  64'd1);
            check_eq($sformatf("w%0d reset out_valid", W), 64'(out_valid), 64'd0);
            check_eq($sformatf("w%0d reset busy", W),      64'(busy),      64'd0);
            check_eq($sformatf("w%0d reset product", W),   64'(product),   64'd0);

            // Operands presented while reset is still high must not be taken.
            @(posedge clk); #2;
            in_valid    = 1'b1;
            signed_mode = dv[0].s;
            mcand       = dv[0].m[W-1:0];
            mplier      = dv[0].q[W-1:0];
            @(posedge clk); #2;
            check_eq($sformatf("w%0d no accept under rst", W), 64'(busy), 64'd0);
            rst = 1'b0;
            @(posedge clk); #2;
            check_eq($sformatf("w%0d first edge accept", W), 64'(busy), 64'd1);
            exp_q.push_back(dv[0].e);
            acc_q.push_back(cyc);
            in_valid = 1'b0;
            mcand    = W'($urandom);
            mplier   = W'($urandom);
            wait_idle();

            // Back-to-back with out_ready high gives one result every W+3 cycles.
            issue(dv[1].s, dv[1].m, dv[1].q, dv[1].e);
            a0 = last_acc;
            issue(dv[2].s, dv[2].m, dv[2].q, dv[2].e);
            check_eq($sformatf("w%0d throughput", W), 64'(last_acc - a0), 64'(W + 3));
            for (int i = 3; i < dv.size(); i++) issue(dv[i].s, dv[i].m, dv[i].q, dv[i].e);
            wait_idle();

            // New operands offered mid-RUN are ignored.
            issue(1'b1, 32'h5, 32'hFFFF_FFFD, ref_mul(W, 1'b1, 32'h5, 32'hFFFF_FFFD));
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                mcand    = W'($urandom);
                mplier   = W'($urandom);
                check_eq($sformatf("w%0d in_ready low in RUN", W), 64'(in_ready), 64'd0);
                check_eq($sformatf("w%0d busy in RUN", W),         64'(busy),     64'd1);
                if (i < 2) begin
                    @(posedge clk); #2;
                end
            end
            in_valid = 1'b0;
            wait_idle();

            // Backpressure: product held in DONE while out_ready stays low.
            hold_off = 1'b1;
            issue(1'b0, 32'h6, 32'h3, 64'd18);
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #2;
                n++;
            end
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #2;
                check_eq($sformatf("w%0d out_valid held", W), 64'(out_valid), 64'd1);
                check_eq($sformatf("w%0d in_ready low in DONE", W), 64'(in_ready), 64'd0);
            end
            hold_off = 1'b0;
            n = 0;
            do begin
                @(posedge clk); #3;
                n++;
            end while (!out_ready && n < 10);
            @(posedge clk); #2;
            check_eq($sformatf("w%0d idle after handshake", W), 64'(in_ready), 64'd1);
            check_eq($sformatf("w%0d out_valid after handshake", W), 64'(out_valid), 64'd0);

            // Reset after RUN step 2 aborts the operation silently.
            wait_ready();
            in_valid    = 1'b1;
            signed_mode = 1'b0;
            mcand       = W'(5);
            mplier      = W'(3);
            @(posedge clk); #2;
            in_valid = 1'b0;
            @(posedge clk); #2;
            @(posedge clk); #2;
            rst = 1'b1;
            @(posedge clk); #2;
            rst = 1'b0;
            check_eq($sformatf("w%0d abort in_ready", W),  64'(in_ready),  64'd1);
            check_eq($sformatf("w%0d abort out_valid", W), 64'(out_valid), 64'd0);
            check_eq($sformatf("w%0d abort busy", W),      64'(busy),      64'd0);
            check_eq($sformatf("w%0d abort product", W),   64'(product),   64'd0);
            for (int i = 0; i < W + 3; i++) begin
                @(posedge clk); #2;
                check_eq($sformatf("w%0d no out_valid after abort", W), 64'(out_valid), 64'd0);
            end
            issue(1'b0, 32'd7, 32'd1, 64'd7);
            wait_idle();

            rnd_ready = 1'b1;
            for (int i = 0; i < 500; i++) begin
                bit          s;
                logic [31:0] m;
                logic [31:0] q;
                s = 1'($urandom);
                m = $urandom;
                q = $urandom;
                issue(s, m, q, ref_mul(W, s, m, q));
            end
            wait_idle();
            rnd_ready = 1'b0;
            check_eq($sformatf("w%0d scoreboard drained", W), 64'(exp_q.size()), 64'd0);
            done_w[gi] = 1'b1;
        end
    end

    initial begin : finisher
        int n = 0;
        while (!(done_w[0] && done_w[1]) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(done_w[0] && done_w[1])) begin
            checks++;
            errors++;
            $display("FAIL global timeout: got done=%0b%0b expected 11", done_w[1], done_w[0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
